// File: rtl/piso_tx.sv
// Parallel-in serial-out byte transmitter: start bit, 8 data bits LSB first, stop bit, DIV clocks per bit.
// Optional even-parity bit between data and stop when PISO_TX_PARITY_EN is defined.
module piso_tx #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       load,
    output logic       ready,
    output logic       txd,
    output logic       busy,
    output logic       done
);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    state_t     state_q;
    logic [7:0] shift_q;
    logic [2:0] bit_q;
    logic [7:0] div_q;
    logic [7:0] div_d;
    logic       txd_q;
    logic       done_q;
    logic       bit_end;
`ifdef PISO_TX_PARITY_EN
    logic       par_q;
`endif

    always_comb begin
        bit_end = (div_q == DIV_LAST);
        div_d   = bit_end ? 8'd0 : div_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= 8'd0;
            bit_q   <= 3'd0;
            div_q   <= 8'd0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    div_q <= 8'd0;
                    bit_q <= 3'd0;
                    if (load) begin
                        shift_q <= din;
                        txd_q   <= 1'b0;
                        state_q <= START;
`ifdef PISO_TX_PARITY_EN
                        par_q   <= ^din;
`endif
                    end
                end
                START: begin
                    div_q <= div_d;
                    if (bit_end) begin
                        txd_q   <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    div_q <= div_d;
                    if (bit_end) begin
                        if (bit_q == 3'd7) begin
                            bit_q <= 3'd0;
`ifdef PISO_TX_PARITY_EN
                            txd_q   <= par_q;
                            state_q <= PARITY;
`else
                            txd_q   <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            // shift_q[0] already holds the next bit: one shift happened on entry
                            bit_q   <= bit_q + 3'd1;
                            txd_q   <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end
                end
`ifdef PISO_TX_PARITY_EN
                PARITY: begin
                    div_q <= div_d;
                    if (bit_end) begin
                        txd_q   <= 1'b1;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    div_q <= div_d;
                    if (bit_end) begin
                        txd_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = ~ready;
    assign txd   = txd_q;
    assign done  = done_q;

endmodule
